// File: rtl/ex_stage_pkg.sv
// Shared decode/execute encodings: result classes, operation subtypes,
// multiplier FSM states and a small operand-magnitude helper.
package ex_stage_pkg;

  // Result class (alusel)
  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_MOVE  = 3'b011;

  // Operation subtype (aluop)
  localparam logic [7:0] ALUOP_AND   = 8'h24;
  localparam logic [7:0] ALUOP_OR    = 8'h25;
  localparam logic [7:0] ALUOP_XOR   = 8'h26;
  localparam logic [7:0] ALUOP_NOR   = 8'h27;
  localparam logic [7:0] ALUOP_SLL   = 8'h7C;
  localparam logic [7:0] ALUOP_SRL   = 8'h02;
  localparam logic [7:0] ALUOP_SRA   = 8'h03;
  localparam logic [7:0] ALUOP_MOVZ  = 8'h0A;
  localparam logic [7:0] ALUOP_MOVN  = 8'h0B;
  localparam logic [7:0] ALUOP_MFHI  = 8'h10;
  localparam logic [7:0] ALUOP_MTHI  = 8'h11;
  localparam logic [7:0] ALUOP_MFLO  = 8'h12;
  localparam logic [7:0] ALUOP_MTLO  = 8'h13;
  localparam logic [7:0] ALUOP_MULT  = 8'h18;
  localparam logic [7:0] ALUOP_MULTU = 8'h19;

  // Multiplier sequencing
  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_e;

  // Index of the final shift-add iteration (32 iterations: 0..31)
  localparam logic [4:0] MUL_LAST_ITER = 5'd31;

  // Magnitude of a 32-bit operand; only negative signed values are negated.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] m;
    if (is_signed && v[31]) begin
      m = (~v) + 32'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative radix-2 shift-add multiplier. Operands are captured as
// magnitudes on the IDLE->BUSY edge, 32 iterations run in BUSY, and the
// sign-corrected 64-bit product is presented for one cycle in DONE.
module mul_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mul_state_e  state_r;
  mul_state_e  state_s;
  logic [4:0]  cnt_r;
  logic [63:0] mcand_r;
  logic [31:0] mplier_r;
  logic [63:0] partial_r;
  logic        neg_r;

  // Next-state selection; a flush from any state abandons the operation
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = MUL_IDLE;
    end else begin
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            state_s = MUL_BUSY;
          end else begin
            state_s = MUL_IDLE;
          end
        end
        MUL_BUSY: begin
          if (cnt_r == MUL_LAST_ITER) begin
            state_s = MUL_DONE;
          end else begin
            state_s = MUL_BUSY;
          end
        end
        MUL_DONE: state_s = MUL_IDLE;
        default:  state_s = MUL_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MUL_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture on start, then one shift-add step per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= 5'd0;
      mcand_r   <= 64'd0;
      mplier_r  <= 32'd0;
      partial_r <= 64'd0;
      neg_r     <= 1'b0;
    end else if ((state_r == MUL_IDLE) && start && !flush) begin
      cnt_r     <= 5'd0;
      mcand_r   <= {32'd0, mag32(op_a, is_signed)};
      mplier_r  <= mag32(op_b, is_signed);
      partial_r <= 64'd0;
      neg_r     <= is_signed & (op_a[31] ^ op_b[31]);
    end else if ((state_r == MUL_BUSY) && !flush) begin
      if (mplier_r[0]) begin
        partial_r <= partial_r + mcand_r;
      end
      mcand_r  <= {mcand_r[62:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[31:1]};
      cnt_r    <= cnt_r + 5'd1;
    end
  end

  // Status flags and sign-corrected product
  always_comb begin
    idle    = (state_r == MUL_IDLE);
    busy    = (state_r == MUL_BUSY);
    done    = (state_r == MUL_DONE);
    product = partial_r;
    if (neg_r) begin
      product = (~partial_r) + 64'd1;
    end else begin
      product = partial_r;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: logic/shift/move result mux, HI/LO architectural registers,
// and the multi-cycle multiply with its pipeline stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        is_mul_s;
  logic        mul_signed_s;
  logic        mul_idle_s;
  logic        mul_busy_s;
  logic        mul_done_s;
  logic [63:0] mul_product_s;
  logic [31:0] logic_res_s;
  logic [31:0] shift_res_s;
  logic [31:0] move_res_s;
  logic [31:0] result_s;

  assign is_mul_s     = (aluop_i == ALUOP_MULT) || (aluop_i == ALUOP_MULTU);
  assign mul_signed_s = (aluop_i == ALUOP_MULT);

  mul_iter u_mul (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_i),
    .start     (is_mul_s),
    .is_signed (mul_signed_s),
    .op_a      (reg1_i),
    .op_b      (reg2_i),
    .idle      (mul_idle_s),
    .busy      (mul_busy_s),
    .done      (mul_done_s),
    .product   (mul_product_s)
  );

  // Hold the pipeline from multiply issue until the product is ready
  always_comb begin
    stall_req_o = 1'b0;
    if (rst) begin
      stall_req_o = 1'b0;
    end else if ((mul_idle_s && is_mul_s) || mul_busy_s) begin
      stall_req_o = 1'b1;
    end else begin
      stall_req_o = 1'b0;
    end
  end

  // HI/LO update; flush outranks every write source
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (flush_i) begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end else if (mul_done_s) begin
      hi_r <= mul_product_s[63:32];
      lo_r <= mul_product_s[31:0];
    end else if (!stall_req_o && (aluop_i == ALUOP_MTHI)) begin
      hi_r <= reg1_i;
    end else if (!stall_req_o && (aluop_i == ALUOP_MTLO)) begin
      lo_r <= reg1_i;
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

  // Bitwise logic results
  always_comb begin
    logic_res_s = 32'd0;
    case (aluop_i)
      ALUOP_OR:  logic_res_s = reg1_i | reg2_i;
      ALUOP_AND: logic_res_s = reg1_i & reg2_i;
      ALUOP_XOR: logic_res_s = reg1_i ^ reg2_i;
      ALUOP_NOR: logic_res_s = ~(reg1_i | reg2_i);
      default:   logic_res_s = 32'd0;
    endcase
  end

  // Shift results; the shift amount is the low five bits of operand 1
  always_comb begin
    shift_res_s = 32'd0;
    case (aluop_i)
      ALUOP_SLL: shift_res_s = reg2_i << reg1_i[4:0];
      ALUOP_SRL: shift_res_s = reg2_i >> reg1_i[4:0];
      ALUOP_SRA: shift_res_s = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:   shift_res_s = 32'd0;
    endcase
  end

  // Move results, including reads of HI/LO
  always_comb begin
    move_res_s = 32'd0;
    case (aluop_i)
      ALUOP_MOVZ: move_res_s = reg1_i;
      ALUOP_MOVN: move_res_s = reg1_i;
      ALUOP_MFHI: move_res_s = hi_r;
      ALUOP_MFLO: move_res_s = lo_r;
      default:    move_res_s = 32'd0;
    endcase
  end

  // Select the result class
  always_comb begin
    result_s = 32'd0;
    case (alusel_i)
      ALUSEL_LOGIC: result_s = logic_res_s;
      ALUSEL_SHIFT: result_s = shift_res_s;
      ALUSEL_MOVE:  result_s = move_res_s;
      ALUSEL_NOP:   result_s = 32'd0;
      default:      result_s = 32'd0;
    endcase
  end

  // Writeback outputs pass through combinationally, forced quiet in reset
  always_comb begin
    wdata_o = 32'd0;
    wd_o    = 5'd0;
    wreg_o  = 1'b0;
    if (rst) begin
      wdata_o = 32'd0;
      wd_o    = 5'd0;
      wreg_o  = 1'b0;
    end else begin
      wdata_o = result_s;
      wd_o    = wd_i;
      wreg_o  = wreg_i;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp;
  int n_bad;
  int n_stall;

  ex_stage dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .flush_i     (flush_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    alusel_i = sel;
    aluop_i  = op;
    reg1_i   = a;
    reg2_i   = b;
    #1;
  endtask

  // Issue a multiply and count stall cycles until it deasserts (in DONE)
  task automatic run_mul(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n);
    set_op(ALUSEL_NOP, op, a, b);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!stall_req_o) break;
      n++;
      cyc();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    flush_i = 1'b0;
    wreg_i  = 1'b1;
    wd_i    = 5'd7;
    alusel_i = ALUSEL_LOGIC;
    aluop_i  = ALUOP_OR;
    reg1_i   = 32'h0000FF00;
    reg2_i   = 32'h00FF0000;
    rst      = 1'b1;

    // Reset behaviour
    cyc();
    cyc();
    chk_val("rst_wdata", wdata_o, 32'h0);
    chk_val("rst_wreg", 32'(wreg_o), 32'h0);
    chk_val("rst_wd", 32'(wd_o), 32'h0);
    chk_val("rst_stall", 32'(stall_req_o), 32'h0);
    chk_val("rst_hi", hi_o, 32'h0);
    chk_val("rst_lo", lo_o, 32'h0);
    rst = 1'b0;
    cyc();

    // Logic class
    wd_i = 5'd5;
    set_op(ALUSEL_LOGIC, ALUOP_OR, 32'h0000FF00, 32'h00FF0000);
    chk_val("or_wdata", wdata_o, 32'h00FFFF00);
    chk_val("or_wd", 32'(wd_o), 32'd5);
    chk_val("or_wreg", 32'(wreg_o), 32'd1);
    chk_val("or_stall", 32'(stall_req_o), 32'd0);
    set_op(ALUSEL_LOGIC, ALUOP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_val("and", wdata_o, 32'hF000F000);
    set_op(ALUSEL_LOGIC, ALUOP_XOR, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_val("xor", wdata_o, 32'h0FF00FF0);
    set_op(ALUSEL_LOGIC, ALUOP_NOR, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_val("nor", wdata_o, 32'h000F000F);
    set_op(ALUSEL_LOGIC, 8'hFF, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_val("unknown_op", wdata_o, 32'h0);
    set_op(ALUSEL_NOP, ALUOP_OR, 32'hF0F0F0F0, 32'hFF00FF00);
    chk_val("nop_class", wdata_o, 32'h0);

    // Shift class
    set_op(ALUSEL_SHIFT, ALUOP_SRA, 32'd4, 32'hF0000000);
    chk_val("sra", wdata_o, 32'hFF000000);
    set_op(ALUSEL_SHIFT, ALUOP_SRL, 32'd4, 32'hF0000000);
    chk_val("srl", wdata_o, 32'h0F000000);
    set_op(ALUSEL_SHIFT, ALUOP_SLL, 32'h00000024, 32'h0000000F);
    chk_val("sll_amt5", wdata_o, 32'h000000F0);
    set_op(ALUSEL_SHIFT, ALUOP_SRA, 32'd31, 32'h40000000);
    chk_val("sra_pos31", wdata_o, 32'h0);

    // Move class
    set_op(ALUSEL_MOVE, ALUOP_MOVZ, 32'hDEADBEEF, 32'h0);
    chk_val("movz", wdata_o, 32'hDEADBEEF);

    // MULT -1 x 2, then MFHI / MFLO
    run_mul(ALUOP_MULT, 32'hFFFFFFFF, 32'h00000002, n_stall);
    chk_val("mult_stall_cycles", 32'(n_stall), 32'd33);
    cyc();
    set_op(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0);
    chk_val("mfhi_after_mult", wdata_o, 32'hFFFFFFFF);
    chk_val("mfhi_stall", 32'(stall_req_o), 32'd0);
    cyc();
    set_op(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0);
    chk_val("mflo_after_mult", wdata_o, 32'hFFFFFFFE);
    cyc();

    // MULTU max x max
    run_mul(ALUOP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n_stall);
    chk_val("multu_stall_cycles", 32'(n_stall), 32'd33);
    cyc();
    set_op(ALUSEL_NOP, 8'h00, 32'h0, 32'h0);
    chk_val("multu_hi", hi_o, 32'hFFFFFFFE);
    chk_val("multu_lo", lo_o, 32'h00000001);

    // MULT most-negative x most-negative
    run_mul(ALUOP_MULT, 32'h80000000, 32'h80000000, n_stall);
    cyc();
    set_op(ALUSEL_NOP, 8'h00, 32'h0, 32'h0);
    chk_val("mult_minneg_hi", hi_o, 32'h40000000);
    chk_val("mult_minneg_lo", lo_o, 32'h00000000);

    // MTLO then MFLO
    set_op(ALUSEL_NOP, ALUOP_MTLO, 32'hCAFEF00D, 32'h0);
    cyc();
    set_op(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0);
    chk_val("mtlo_mflo", wdata_o, 32'hCAFEF00D);

    // MTHI, then a flushed MTHI must not write
    set_op(ALUSEL_NOP, ALUOP_MTHI, 32'h12345678, 32'h0);
    cyc();
    chk_val("mthi", hi_o, 32'h12345678);
    set_op(ALUSEL_NOP, ALUOP_MTHI, 32'h99999999, 32'h0);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    set_op(ALUSEL_NOP, 8'h00, 32'h0, 32'h0);
    chk_val("mthi_flushed", hi_o, 32'h12345678);

    // MULT flushed at BUSY cycle 10
    set_op(ALUSEL_NOP, ALUOP_MULT, 32'd7, 32'd9);
    chk_val("mult_idle_stall", 32'(stall_req_o), 32'd1);
    cyc();
    repeat (9) cyc();
    chk_val("busy10_stall", 32'(stall_req_o), 32'd1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    set_op(ALUSEL_NOP, 8'h00, 32'h0, 32'h0);
    chk_val("flush_stall", 32'(stall_req_o), 32'd0);
    chk_val("flush_hi", hi_o, 32'h12345678);
    repeat (40) cyc();
    chk_val("flush_hi_late", hi_o, 32'h12345678);
    chk_val("flush_lo_late", lo_o, 32'hCAFEF00D);

    // Reset at BUSY cycle 20
    set_op(ALUSEL_NOP, ALUOP_MULT, 32'h00001234, 32'h00000010);
    cyc();
    repeat (19) cyc();
    rst    = 1'b1;
    wreg_i = 1'b1;
    wd_i   = 5'd9;
    #1;
    chk_val("rstbusy_stall", 32'(stall_req_o), 32'd0);
    chk_val("rstbusy_wreg", 32'(wreg_o), 32'd0);
    chk_val("rstbusy_wd", 32'(wd_o), 32'd0);
    cyc();
    rst = 1'b0;
    set_op(ALUSEL_NOP, 8'h00, 32'h0, 32'h0);
    chk_val("rstbusy_hi", hi_o, 32'h0);
    chk_val("rstbusy_lo", lo_o, 32'h0);
    chk_val("rstbusy_stall_after", 32'(stall_req_o), 32'd0);
    repeat (40) cyc();
    chk_val("rstbusy_lo_late", lo_o, 32'h0);

    // Fresh multiply after reset
    run_mul(ALUOP_MULT, 32'd3, 32'd5, n_stall);
    chk_val("mult3x5_stall_cycles", 32'(n_stall), 32'd33);
    cyc();
    set_op(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0);
    chk_val("mult3x5_mflo", wdata_o, 32'd15);
    chk_val("mult3x5_hi", hi_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Reset is rst, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for the HI/LO registers and the multiplier FSM.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 aluop_i  input  8  operation subtype from the ID/EX register.
REQ-005 alusel_i  input  3  result class: NOP 000, LOGIC 001, SHIFT 010, MOVE 011.
REQ-006 reg1_i  input  32  operand 1: rs value, or immediate/shamt as supplied by decode.
REQ-007 reg2_i  input  32  operand 2: rt value, or immediate as supplied by decode.
REQ-008 wd_i  input  5  destination register address.
REQ-009 wreg_i  input  1  destination write enable.
REQ-010 flush_i  input  1  abort the in-flight instruction.
REQ-011 wd_o  output  5  destination address, equal to wd_i, combinational.
REQ-012 wreg_o  output  1  write enable, equal to wreg_i, combinational.
REQ-013 wdata_o  output  32  result, combinational; feeds the EX/MEM register and decode forwarding.
REQ-014 stall_req_o  output  1  pipeline hold request while a multiply is incomplete.
REQ-015 hi_o, lo_o  output  32 each  current architectural HI/LO values.

Function
REQ-016 LOGIC class: OR, AND, XOR and NOR of reg1_i with reg2_i (aluop 0x25, 0x24, 0x26, 0x27).
REQ-017 SHIFT class: SLL (0x7C), SRL (0x02) and SRA (0x03) shift reg2_i by reg1_i[4:0]; SRA sign-fills from reg2_i[31].
REQ-018 MOVE class: MOVZ/MOVN (0x0A/0x0B) output reg1_i; MFHI (0x10) outputs HI; MFLO (0x12) outputs LO.
REQ-019 NOP class or an unknown aluop gives wdata_o = 0.
REQ-020 MTHI (0x11) and MTLO (0x13) write reg1_i into HI or LO at the next clock edge when stall_req_o is 0.
REQ-021 MULT (0x18, signed) and MULTU (0x19, unsigned) give a 64-bit product; HI receives [63:32] and LO receives [31:0].
REQ-022 Multiplier FSM states and transitions:
- IDLE: on a MULT/MULTU, go to BUSY.
- BUSY: 32 iterations of radix-2 shift-add on the operand magnitudes, then go to DONE.
- DONE: write HI/LO with the sign-corrected product, then return to IDLE.
REQ-023 stall_req_o is 1 combinationally in IDLE when aluop_i is MULT/MULTU, and 1 throughout BUSY; it is 0 in DONE and at all other times.
REQ-024 A multiply therefore holds EX for exactly 34 cycles: 1 IDLE, 32 BUSY, 1 DONE.
REQ-025 Upstream holds all inputs stable while stall_req_o is 1; the operands are captured on the IDLE->BUSY edge.
REQ-026 HI/LO are written on the edge that ends DONE, so an MFHI/MFLO entering EX on the next cycle reads the new value.
REQ-027 flush_i = 1 in any state returns the FSM to IDLE on the next edge with no HI/LO write; flush has priority over every HI/LO write.
REQ-028 Signed boundary: 0x80000000 x 0x80000000 (MULT) gives HI = 0x40000000, LO = 0x00000000.

Reset
REQ-029 With rst = 1, on the next edge: FSM to IDLE, HI = 0, LO = 0, iteration counter = 0, partial product = 0.
REQ-030 While rst = 1: stall_req_o = 0, wdata_o = 0, wreg_o = 0, wd_o = 0.
REQ-031 Reset asserted during BUSY discards the multiply; no HI/LO update.

Structure
REQ-032 Aluop and alusel codes come from the shared define header that decode also uses; no local copies are kept.
REQ-033 The iterative multiplier is the sub-module mul_iter: start/operands/signed in, 64-bit product plus done pulse out. HI/LO and result muxing stay in ex_stage.

Verification
REQ-034 OR 0x0000FF00 with 0x00FF0000, wreg_i = 1, wd_i = 5 -> wdata_o = 0x00FFFF00, wd_o = 5, wreg_o = 1, stall_req_o = 0.
REQ-035 SRA with reg2_i = 0xF0000000, reg1_i = 4 -> wdata_o = 0xFF000000; SRL with the same operands -> 0x0F000000.
REQ-036 MULT 0xFFFFFFFF x 0x00000002, then MFHI, then MFLO:
- stall_req_o is 1 for exactly 33 cycles.
- Following MFHI returns 0xFFFFFFFF; MFLO returns 0xFFFFFFFE.
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; MULT 0x80000000 x 0x80000000 -> HI = 0x40000000, LO = 0x00000000.
REQ-038 MTHI 0x12345678, then MULT with flush_i pulsed at BUSY cycle 10 -> FSM in IDLE, HI stays 0x12345678, stall_req_o deasserts the next cycle.
REQ-039 rst asserted at BUSY cycle 20 -> HI = LO = 0, stall_req_o = 0; a new MULT 3 x 5 afterwards gives LO = 15, HI = 0.
